y86_pipe_regs: RTL and testbench

Bank of the five Y86 pipeline registers (F, D, E, M, W) that carry instruction state between stages. Each register applies the stall, bubble and write-stall commands generated by the pipeline hazard control unit on every clock edge. It is the consumer of those control signals and sits between the stage logic blocks (fetch, decode, execute, memory, writeback). It also keeps cycle and retired-instruction counters for the testbench.

---
 rtl/y86_pkg.sv | 49 ++++
 rtl/y86_pipe_regs_if.sv | 46 ++++
 rtl/pipe_stage_reg.sv | 16 +
 rtl/y86_pipe_regs.sv | 60 ++++++
 tb/tb_y86_pipe_regs.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: Y86 status/opcode encodings and pipeline register bundles with their bubble values.
package y86_pkg;
    localparam int WORD_W = 64;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [3:0] nib_t;

    localparam nib_t STAT_AOK = 4'b1000;
    localparam nib_t STAT_HLT = 4'b0100;
    localparam nib_t STAT_ADR = 4'b0010;
    localparam nib_t STAT_INS = 4'b0001;

    localparam nib_t I_HALT   = 4'h0;
    localparam nib_t I_NOP    = 4'h1;
    localparam nib_t I_IRMOVQ = 4'h3;
    localparam nib_t I_MRMOVQ = 4'h5;
    localparam nib_t I_JXX    = 4'h7;
    localparam nib_t I_RET    = 4'h9;
    localparam nib_t I_POPQ   = 4'hB;
    localparam nib_t RNONE    = 4'hF;

    typedef struct packed {
        nib_t stat, icode, ifun, rA, rB;
        word_t valC, valP;
    } d_reg_t;

    typedef struct packed {
        nib_t stat, icode, ifun;
        word_t valC, valA, valB;
        nib_t dstE, dstM, srcA, srcB;
    } e_reg_t;

    typedef struct packed {
        nib_t stat, icode, ifun;
        logic cnd;
        word_t valE, valA;
        nib_t dstE, dstM;
    } m_reg_t;

    typedef struct packed {
        nib_t stat, icode;
        word_t valE, valM;
        nib_t dstE, dstM;
    } w_reg_t;

    localparam d_reg_t D_BUBBLE = '{STAT_AOK, I_NOP, 4'h0, RNONE, RNONE, '0, '0};
    localparam e_reg_t E_BUBBLE = '{STAT_AOK, I_NOP, 4'h0, '0, '0, '0, RNONE, RNONE, RNONE, RNONE};
    localparam m_reg_t M_BUBBLE = '{STAT_AOK, I_NOP, 4'h0, 1'b0, '0, '0, RNONE, RNONE};
    localparam w_reg_t W_BUBBLE = '{STAT_AOK, I_NOP, '0, '0, RNONE, RNONE};
endpackage

// File: rtl/y86_pipe_regs_if.sv
// y86_pipe_regs_if: signals between the stage logic / hazard control and the pipeline register bank.
interface y86_pipe_regs_if #(parameter int W_WORD = 64, parameter int W_CNT = 32);
    logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic [W_WORD-1:0] f_predPC, F_predPC;
    logic [3:0] f_stat, f_icode, f_ifun, f_rA, f_rB;
    logic [W_WORD-1:0] f_valC, f_valP;
    logic [3:0] D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [W_WORD-1:0] D_valC, D_valP;
    logic [3:0] d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
    logic [W_WORD-1:0] d_valC, d_valA, d_valB;
    logic [3:0] E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [W_WORD-1:0] E_valC, E_valA, E_valB;
    logic [3:0] e_stat, e_dstE;
    logic e_cnd;
    logic [W_WORD-1:0] e_valE;
    logic [3:0] M_stat, M_icode, M_ifun, M_dstE, M_dstM;
    logic M_cnd;
    logic [W_WORD-1:0] M_valE, M_valA;
    logic [3:0] m_stat;
    logic [W_WORD-1:0] m_valM;
    logic [3:0] W_stat, W_icode, W_dstE, W_dstM;
    logic [W_WORD-1:0] W_valE, W_valM;
    logic [W_CNT-1:0] cycle_count, instr_count;

    modport master (
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        output f_predPC, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
        output d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB, d_valC, d_valA, d_valB,
        output e_stat, e_dstE, e_cnd, e_valE, m_stat, m_valM,
        input  F_predPC, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB,
        input  M_stat, M_icode, M_ifun, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
        input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, cycle_count, instr_count
    );

    modport slave (
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        input  f_predPC, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
        input  d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB, d_valC, d_valA, d_valB,
        input  e_stat, e_dstE, e_cnd, e_valE, m_stat, m_valM,
        output F_predPC, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB,
        output M_stat, M_icode, M_ifun, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
        output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, cycle_count, instr_count
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register; reset beats stall, stall beats bubble.
module pipe_stage_reg #(
    parameter int W = 1,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        if (!rst_n) q <= BUBBLE;
        else if (!stall) q <= bubble ? BUBBLE : d;
endmodule

// File: rtl/y86_pipe_regs.sv
// y86_pipe_regs: F/D/E/M/W pipeline registers driven by hazard control, plus cycle and retired-instruction counters.
module y86_pipe_regs import y86_pkg::*; #(
    parameter int W_WORD = WORD_W,
    parameter int W_CNT  = 32
) (
    input logic clk,
    input logic rst_n,
    y86_pipe_regs_if.slave bus
);
    d_reg_t d_in, d_q;
    e_reg_t e_in, e_q;
    m_reg_t m_in, m_q;
    w_reg_t w_in, w_q;
    logic [W_WORD-1:0] f_q;
    logic [W_CNT-1:0] cyc_q, cyc_d, ins_q, ins_d;

    assign d_in = '{bus.f_stat, bus.f_icode, bus.f_ifun, bus.f_rA, bus.f_rB, bus.f_valC, bus.f_valP};
    assign e_in = '{bus.d_stat, bus.d_icode, bus.d_ifun, bus.d_valC, bus.d_valA, bus.d_valB,
                    bus.d_dstE, bus.d_dstM, bus.d_srcA, bus.d_srcB};
    // M and W pass some fields straight through from the upstream register
    assign m_in = '{bus.e_stat, e_q.icode, e_q.ifun, bus.e_cnd, bus.e_valE, e_q.valA, bus.e_dstE, e_q.dstM};
    assign w_in = '{bus.m_stat, m_q.icode, m_q.valE, bus.m_valM, m_q.dstE, m_q.dstM};

    pipe_stage_reg #(.W(W_WORD), .BUBBLE('0)) u_f (
        .clk(clk), .rst_n(rst_n), .stall(bus.F_stall), .bubble(1'b0), .d(bus.f_predPC), .q(f_q));
    pipe_stage_reg #(.W($bits(d_reg_t)), .BUBBLE(D_BUBBLE)) u_d (
        .clk(clk), .rst_n(rst_n), .stall(bus.D_stall), .bubble(bus.D_bubble), .d(d_in), .q(d_q));
    pipe_stage_reg #(.W($bits(e_reg_t)), .BUBBLE(E_BUBBLE)) u_e (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .bubble(bus.E_bubble), .d(e_in), .q(e_q));
    pipe_stage_reg #(.W($bits(m_reg_t)), .BUBBLE(M_BUBBLE)) u_m (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .bubble(bus.M_bubble), .d(m_in), .q(m_q));
    pipe_stage_reg #(.W($bits(w_reg_t)), .BUBBLE(W_BUBBLE)) u_w (
        .clk(clk), .rst_n(rst_n), .stall(bus.W_stall), .bubble(1'b0), .d(w_in), .q(w_q));

    assign bus.F_predPC = f_q;
    assign {bus.D_stat, bus.D_icode, bus.D_ifun, bus.D_rA, bus.D_rB, bus.D_valC, bus.D_valP} = d_q;
    assign {bus.E_stat, bus.E_icode, bus.E_ifun, bus.E_valC, bus.E_valA, bus.E_valB,
            bus.E_dstE, bus.E_dstM, bus.E_srcA, bus.E_srcB} = e_q;
    assign {bus.M_stat, bus.M_icode, bus.M_ifun, bus.M_cnd, bus.M_valE, bus.M_valA,
            bus.M_dstE, bus.M_dstM} = m_q;
    assign {bus.W_stat, bus.W_icode, bus.W_valE, bus.W_valM, bus.W_dstE, bus.W_dstM} = w_q;

    // counters saturate; a held W entry or a nop never counts as retired
    always_comb begin
        cyc_d = (w_q.stat == STAT_AOK && cyc_q != '1) ? cyc_q + W_CNT'(1) : cyc_q;
        ins_d = (!bus.W_stall && w_in.icode != I_NOP && ins_q != '1) ? ins_q + W_CNT'(1) : ins_q;
    end

    always_ff @(posedge clk)
        if (!rst_n) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ins_q <= ins_d;
        end

    assign bus.cycle_count = cyc_q;
    assign bus.instr_count = ins_q;
endmodule

// File: tb/tb_y86_pipe_regs.sv
// tb_y86_pipe_regs: random + directed stimulus, reference model feeds a scoreboard checked by a negedge monitor.
module tb_y86_pipe_regs;
    import y86_pkg::*;

    typedef struct {
        logic [63:0] fpc;
        logic [3:0]  ds, di, df, dra, drb;
        logic [63:0] dvc, dvp;
        logic [3:0]  es, ei, ef;
        logic [63:0] evc, eva, evb;
        logic [3:0]  ede, edm, esa, esb;
        logic [3:0]  ms, mi, mf;
        logic        mc;
        logic [63:0] mve, mva;
        logic [3:0]  mde, mdm;
        logic [3:0]  ws, wi;
        logic [63:0] wve, wvm;
        logic [3:0]  wde, wdm;
        logic [31:0] cyc, ins;
    } st_t;

    typedef struct {
        logic        rst_n, fs, ds, db, eb, mb, ws;
        logic [63:0] fpc;
        logic [3:0]  fst, fic, ffn, fra, frb;
        logic [63:0] fvc, fvp;
        logic [3:0]  dst, dic, dfn, dde, ddm, dsa, dsb;
        logic [63:0] dvc, dva, dvb;
        logic [3:0]  est, ede;
        logic        ecnd;
        logic [63:0] eve;
        logic [3:0]  mst;
        logic [63:0] mvm;
    } in_t;

    logic clk = 1'b0;
    logic rst_n;
    int total = 0;
    int bad = 0;
    st_t model;
    st_t sb[$];

    y86_pipe_regs_if bus();
    y86_pipe_regs dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic st_t reset_st();
        st_t r;
        r.fpc = 0;
        r.ds = STAT_AOK; r.di = I_NOP; r.df = 0; r.dra = RNONE; r.drb = RNONE; r.dvc = 0; r.dvp = 0;
        r.es = STAT_AOK; r.ei = I_NOP; r.ef = 0; r.evc = 0; r.eva = 0; r.evb = 0;
        r.ede = RNONE; r.edm = RNONE; r.esa = RNONE; r.esb = RNONE;
        r.ms = STAT_AOK; r.mi = I_NOP; r.mf = 0; r.mc = 0; r.mve = 0; r.mva = 0; r.mde = RNONE; r.mdm = RNONE;
        r.ws = STAT_AOK; r.wi = I_NOP; r.wve = 0; r.wvm = 0; r.wde = RNONE; r.wdm = RNONE;
        r.cyc = 0; r.ins = 0;
        return r;
    endfunction

    // bubble value of every stage equals its post-reset value
    function automatic st_t next_st(st_t s, in_t i);
        st_t n, b;
        b = reset_st();
        if (!i.rst_n) return b;
        n = s;
        if (!i.fs) n.fpc = i.fpc;
        if (!i.ds) begin
            if (i.db) {n.ds, n.di, n.df, n.dra, n.drb, n.dvc, n.dvp} = {b.ds, b.di, b.df, b.dra, b.drb, b.dvc, b.dvp};
            else      {n.ds, n.di, n.df, n.dra, n.drb, n.dvc, n.dvp} = {i.fst, i.fic, i.ffn, i.fra, i.frb, i.fvc, i.fvp};
        end
        if (i.eb) {n.es, n.ei, n.ef, n.evc, n.eva, n.evb, n.ede, n.edm, n.esa, n.esb} =
                  {b.es, b.ei, b.ef, b.evc, b.eva, b.evb, b.ede, b.edm, b.esa, b.esb};
        else      {n.es, n.ei, n.ef, n.evc, n.eva, n.evb, n.ede, n.edm, n.esa, n.esb} =
                  {i.dst, i.dic, i.dfn, i.dvc, i.dva, i.dvb, i.dde, i.ddm, i.dsa, i.dsb};
        if (i.mb) {n.ms, n.mi, n.mf, n.mc, n.mve, n.mva, n.mde, n.mdm} = {b.ms, b.mi, b.mf, b.mc, b.mve, b.mva, b.mde, b.mdm};
        else      {n.ms, n.mi, n.mf, n.mc, n.mve, n.mva, n.mde, n.mdm} = {i.est, s.ei, s.ef, i.ecnd, i.eve, s.eva, i.ede, s.edm};
        if (!i.ws) {n.ws, n.wi, n.wve, n.wvm, n.wde, n.wdm} = {i.mst, s.mi, s.mve, i.mvm, s.mde, s.mdm};
        if (s.ws == STAT_AOK && s.cyc != 32'hFFFF_FFFF) n.cyc = s.cyc + 1;
        if (!i.ws && s.mi != I_NOP && s.ins != 32'hFFFF_FFFF) n.ins = s.ins + 1;
        return n;
    endfunction

    function automatic logic [3:0] rstat();
        return ($urandom_range(0, 3) == 0) ? (STAT_AOK >> $urandom_range(1, 3)) : STAT_AOK;
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic in_t rnd_in();
        in_t x;
        x.rst_n = 1'b1;
        x.fs = ($urandom_range(0, 3) == 0); x.ds = ($urandom_range(0, 3) == 0);
        x.db = ($urandom_range(0, 3) == 0); x.eb = ($urandom_range(0, 3) == 0);
        x.mb = ($urandom_range(0, 7) == 0); x.ws = ($urandom_range(0, 3) == 0);
        x.fpc = r64();
        x.fst = rstat(); x.fic = 4'($urandom); x.ffn = 4'($urandom); x.fra = 4'($urandom); x.frb = 4'($urandom);
        x.fvc = r64(); x.fvp = r64();
        x.dst = rstat(); x.dic = 4'($urandom); x.dfn = 4'($urandom); x.dde = 4'($urandom); x.ddm = 4'($urandom);
        x.dsa = 4'($urandom); x.dsb = 4'($urandom);
        x.dvc = r64(); x.dva = r64(); x.dvb = r64();
        x.est = rstat(); x.ede = 4'($urandom); x.ecnd = 1'($urandom); x.eve = r64();
        x.mst = rstat(); x.mvm = r64();
        return x;
    endfunction

    function automatic in_t quiet();
        in_t x;
        x = rnd_in();
        {x.fs, x.ds, x.db, x.eb, x.mb, x.ws} = '0;
        x.fst = STAT_AOK; x.dst = STAT_AOK; x.est = STAT_AOK; x.mst = STAT_AOK;
        x.fic = I_NOP; x.dic = I_NOP;
        return x;
    endfunction

    task automatic apply(input in_t x);
        rst_n = x.rst_n;
        bus.F_stall = x.fs; bus.D_stall = x.ds; bus.D_bubble = x.db;
        bus.E_bubble = x.eb; bus.M_bubble = x.mb; bus.W_stall = x.ws;
        bus.f_predPC = x.fpc;
        bus.f_stat = x.fst; bus.f_icode = x.fic; bus.f_ifun = x.ffn; bus.f_rA = x.fra; bus.f_rB = x.frb;
        bus.f_valC = x.fvc; bus.f_valP = x.fvp;
        bus.d_stat = x.dst; bus.d_icode = x.dic; bus.d_ifun = x.dfn; bus.d_dstE = x.dde; bus.d_dstM = x.ddm;
        bus.d_srcA = x.dsa; bus.d_srcB = x.dsb; bus.d_valC = x.dvc; bus.d_valA = x.dva; bus.d_valB = x.dvb;
        bus.e_stat = x.est; bus.e_dstE = x.ede; bus.e_cnd = x.ecnd; bus.e_valE = x.eve;
        bus.m_stat = x.mst; bus.m_valM = x.mvm;
    endtask

    task automatic tick(input in_t x);
        apply(x);
        model = next_st(model, x);
        @(posedge clk);
        sb.push_back(model);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        st_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_F", 256'(bus.F_predPC), 256'(e.fpc));
            chk("sb_D", 256'({bus.D_stat, bus.D_icode, bus.D_ifun, bus.D_rA, bus.D_rB, bus.D_valC, bus.D_valP}),
                        256'({e.ds, e.di, e.df, e.dra, e.drb, e.dvc, e.dvp}));
            chk("sb_E", 256'({bus.E_stat, bus.E_icode, bus.E_ifun, bus.E_valC, bus.E_valA, bus.E_valB,
                              bus.E_dstE, bus.E_dstM, bus.E_srcA, bus.E_srcB}),
                        256'({e.es, e.ei, e.ef, e.evc, e.eva, e.evb, e.ede, e.edm, e.esa, e.esb}));
            chk("sb_M", 256'({bus.M_stat, bus.M_icode, bus.M_ifun, bus.M_cnd, bus.M_valE, bus.M_valA, bus.M_dstE, bus.M_dstM}),
                        256'({e.ms, e.mi, e.mf, e.mc, e.mve, e.mva, e.mde, e.mdm}));
            chk("sb_W", 256'({bus.W_stat, bus.W_icode, bus.W_valE, bus.W_valM, bus.W_dstE, bus.W_dstM}),
                        256'({e.ws, e.wi, e.wve, e.wvm, e.wde, e.wdm}));
            chk("sb_cnt", 256'({bus.cycle_count, bus.instr_count}), 256'({e.cyc, e.ins}));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        in_t x;
        logic [31:0] c0, n0;
        for (int k = 0; k < 2; k++) begin
            x = rnd_in();
            x.rst_n = 1'b0;
            tick(x);
        end
        chk("rst_icode", 256'({bus.D_icode, bus.E_icode, bus.M_icode, bus.W_icode}), 256'(16'h1111));
        chk("rst_stat", 256'({bus.D_stat, bus.E_stat, bus.M_stat, bus.W_stat}), 256'(16'h8888));
        chk("rst_dst", 256'({bus.E_dstE, bus.E_dstM, bus.M_dstE, bus.M_dstM, bus.W_dstE, bus.W_dstM}), 256'(24'hFFFFFF));
        chk("rst_pc_cnt", 256'({bus.F_predPC, bus.cycle_count, bus.instr_count}), 256'(0));

        x = quiet(); x.fpc = 64'h100; x.fic = 4'h6; tick(x);
        chk("stall_pre_pc", 256'(bus.F_predPC), 256'(64'h100));
        x = quiet(); x.fs = 1; x.ds = 1; x.db = 1; x.fpc = 64'h10A; x.fic = 4'h2; tick(x);
        chk("stall_pc", 256'(bus.F_predPC), 256'(64'h100));
        chk("stall_D", 256'(bus.D_icode), 256'(4'h6));
        x = quiet(); x.fpc = 64'h10A; x.fic = 4'h6; x.dic = I_JXX; tick(x);
        chk("unstall_pc", 256'(bus.F_predPC), 256'(64'h10A));

        x = quiet(); x.db = 1; x.eb = 1; x.fpc = 64'h200; tick(x);
        chk("squash_DE", 256'({bus.D_icode, bus.E_icode}), 256'(8'h11));
        chk("squash_F", 256'(bus.F_predPC), 256'(64'h200));

        x = quiet(); x.fic = 4'h2; x.dic = I_MRMOVQ; x.ddm = 4'h3; tick(x);
        x = quiet(); x.fs = 1; x.ds = 1; x.eb = 1; tick(x);
        chk("lu_E", 256'({bus.E_icode, bus.E_dstM}), 256'(8'h1F));
        chk("lu_D", 256'(bus.D_icode), 256'(4'h2));
        chk("lu_M", 256'({bus.M_icode, bus.M_dstM}), 256'(8'h53));

        x = quiet(); x.dic = I_HALT; tick(x);
        x = quiet(); tick(x);
        x = quiet(); x.mst = STAT_HLT; tick(x);
        chk("halt_W", 256'({bus.W_stat, bus.W_icode}), 256'(8'h40));
        c0 = model.cyc; n0 = model.ins;
        for (int k = 0; k < 5; k++) begin
            x = rnd_in(); x.ws = 1; x.rst_n = 1; tick(x);
            chk("freeze_stat", 256'(bus.W_stat), 256'(STAT_HLT));
            chk("freeze_cnt", 256'({bus.cycle_count, bus.instr_count}), 256'({c0, n0}));
        end

        x = rnd_in(); x.rst_n = 0; tick(x);
        for (int k = 0; k < 8; k++) begin
            x = quiet();
            if (k < 3) x.dic = I_IRMOVQ;
            if (k == 3 || k == 4) x.eb = 1;
            tick(x);
        end
        chk("count_instr", 256'(bus.instr_count), 256'(32'd3));
        chk("count_cycle", 256'(bus.cycle_count), 256'(32'd8));

        for (int k = 0; k < 400; k++) begin
            x = rnd_in();
            x.rst_n = ($urandom_range(0, 49) != 0);
            tick(x);
        end

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() != 0) chk("sb_drain", 256'(sb.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
